// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and sizing helpers for the iterative magnitude comparator.
//   cmp_state_e    : controller states (IDLE, SCAN, DONE)
//   cmp_result_t   : one-hot {GT, LT, EQ} result encoding
//   calcNumDigits  : number of DIGIT-wide slices in a WIDTH-bit operand
//   calcStepWidth  : width of the step counter able to hold 1..NDIG
//   calcIndexWidth : width of the slice index (at least one bit)
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t RES_GT = 3'b100;
    localparam cmp_result_t RES_LT = 3'b010;
    localparam cmp_result_t RES_EQ = 3'b001;

    function automatic int calcNumDigits(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calcStepWidth(input int numDigits);
        return $clog2(numDigits) + 1;
    endfunction

    // A single-slice operand still needs a one-bit index register.
    function automatic int calcIndexWidth(input int numDigits);
        return (numDigits > 1) ? $clog2(numDigits) : 1;
    endfunction

endpackage

// File: rtl/digit_magnitude_compare.sv
// ---------------------------------------------------------------------------
// digit_magnitude_compare
// Purely combinational unsigned compare of one DIGIT-bit slice.
//   a_i, b_i : slice of operand A and operand B
//   gt, lt   : a_i > b_i, a_i < b_i
//   eq       : a_i == b_i
// ---------------------------------------------------------------------------
module digit_magnitude_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    // Exactly one of the three flags is asserted for any input pair.
    always_comb begin
        gt = (a_i > b_i);
        lt = (a_i < b_i);
        eq = (a_i == b_i);
    end

endmodule

// File: rtl/iterative_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// iterative_magnitude_comparator
// Multi-cycle WIDTH-bit magnitude comparator. Operands are scanned one
// DIGIT-bit slice per clock, most significant slice first, and the scan
// stops at the first slice that differs. Signed operands are handled by
// flipping the sign bit of both operands at capture time, which maps
// two's-complement ordering onto unsigned ordering.
//   i_CLK, i_RST        : clock (rising edge), async active-high reset
//   i_VALID / o_READY   : request handshake, accepted only in IDLE
//   i_OPERAND_A/B       : operands, captured on the accept edge
//   i_SIGNED            : 1 = two's-complement compare, 0 = unsigned
//   o_VALID / i_READY   : result handshake, result held until consumed
//   o_GT, o_LT, o_EQ    : one-hot result, all zero while o_VALID is low
//   o_STEPS             : slices examined (1..NDIG), zero while idle
// ---------------------------------------------------------------------------
module iterative_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    input  logic             i_SIGNED,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_GT,
    output logic             o_LT,
    output logic             o_EQ,
    output logic [calcStepWidth(calcNumDigits(WIDTH, DIGIT))-1:0] o_STEPS
);

    localparam int NDIG  = calcNumDigits(WIDTH, DIGIT);
    localparam int STEPW = calcStepWidth(NDIG);
    localparam int IDXW  = calcIndexWidth(NDIG);

    // Reject operand widths that do not split into whole slices.
    generate
        if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : gBadParams
            $error("iterative_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [IDXW-1:0]  digitIdx_q, digitIdx_d;
    logic [STEPW-1:0] stepCount_q, stepCount_d;
    cmp_result_t      result_q, result_d;

    logic [WIDTH-1:0] signBias;
    logic [DIGIT-1:0] sliceA;
    logic [DIGIT-1:0] sliceB;
    logic             digitGt;
    logic             digitLt;
    logic             digitEq;
    logic             scanFinished;

    // Flipping the MSB of both operands turns a signed compare into an
    // unsigned one, so the slice comparator never needs to know the mode.
    assign signBias = WIDTH'(i_SIGNED) << (WIDTH - 1);

    assign sliceA = opA_q[digitIdx_q*DIGIT +: DIGIT];
    assign sliceB = opB_q[digitIdx_q*DIGIT +: DIGIT];

    digit_magnitude_compare #(
        .DIGIT (DIGIT)
    ) uDigitCompare (
        .a_i (sliceA),
        .b_i (sliceB),
        .gt  (digitGt),
        .lt  (digitLt),
        .eq  (digitEq)
    );

    // The scan ends at the first differing slice or after the last slice.
    assign scanFinished = !digitEq || (digitIdx_q == '0);

    // State register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_VALID) state_d = SCAN;
            SCAN:    if (scanFinished) state_d = DONE;
            DONE:    if (i_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, slice walk and step count.
    always_comb begin
        opA_d       = opA_q;
        opB_d       = opB_q;
        digitIdx_d  = digitIdx_q;
        stepCount_d = stepCount_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (i_VALID) begin
                    opA_d       = i_OPERAND_A ^ signBias;
                    opB_d       = i_OPERAND_B ^ signBias;
                    digitIdx_d  = IDXW'(NDIG - 1);
                    stepCount_d = '0;
                end
            end
            SCAN: begin
                stepCount_d = stepCount_q + STEPW'(1);
                if (scanFinished) begin
                    result_d = {digitGt, digitLt, digitEq};
                end else begin
                    digitIdx_d = digitIdx_q - IDXW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any result in flight.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            opA_q       <= '0;
            opB_q       <= '0;
            digitIdx_q  <= '0;
            stepCount_q <= '0;
            result_q    <= '0;
        end else begin
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            digitIdx_q  <= digitIdx_d;
            stepCount_q <= stepCount_d;
            result_q    <= result_d;
        end
    end

    // Outputs are driven from registers and forced to zero outside DONE.
    // o_READY is also held low while reset is asserted.
    always_comb begin
        o_READY = 1'b0;
        o_VALID = 1'b0;
        o_GT    = 1'b0;
        o_LT    = 1'b0;
        o_EQ    = 1'b0;
        o_STEPS = '0;
        case (state_q)
            IDLE: o_READY = !i_RST;
            DONE: begin
                o_VALID              = 1'b1;
                {o_GT, o_LT, o_EQ}   = result_q;
                o_STEPS              = stepCount_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iterative_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_iterative_magnitude_comparator
// Bench for the iterative comparator. Two instances share clock and reset:
// a 16-bit/4-bit-slice instance for the directed cases and a 32-bit/8-bit
// slice instance for the randomised run. useWide selects which instance
// the stimulus and observation helpers talk to.
// ---------------------------------------------------------------------------
module tb_iterative_magnitude_comparator;

    logic clock = 1'b0;
    logic reset;

    // 10 time-unit clock period.
    always #5 clock = ~clock;

    logic        valid16, sgn16, cons16;
    logic [15:0] a16, b16;
    logic        rdy16, ov16, gt16, lt16, eq16;
    logic [2:0]  steps16;

    logic        valid32, sgn32, cons32;
    logic [31:0] a32, b32;
    logic        rdy32, ov32, gt32, lt32, eq32;
    logic [2:0]  steps32;

    logic useWide = 1'b0;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    iterative_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .i_CLK       (clock),
        .i_RST       (reset),
        .i_VALID     (valid16),
        .o_READY     (rdy16),
        .i_OPERAND_A (a16),
        .i_OPERAND_B (b16),
        .i_SIGNED    (sgn16),
        .o_VALID     (ov16),
        .i_READY     (cons16),
        .o_GT        (gt16),
        .o_LT        (lt16),
        .o_EQ        (eq16),
        .o_STEPS     (steps16)
    );

    iterative_magnitude_comparator #(.WIDTH(32), .DIGIT(8)) dut32 (
        .i_CLK       (clock),
        .i_RST       (reset),
        .i_VALID     (valid32),
        .o_READY     (rdy32),
        .i_OPERAND_A (a32),
        .i_OPERAND_B (b32),
        .i_SIGNED    (sgn32),
        .o_VALID     (ov32),
        .i_READY     (cons32),
        .o_GT        (gt32),
        .o_LT        (lt32),
        .o_EQ        (eq32),
        .o_STEPS     (steps32)
    );

    wire       obsReady = useWide ? rdy32 : rdy16;
    wire       obsValid = useWide ? ov32  : ov16;
    wire [2:0] obsRes   = useWide ? {gt32, lt32, eq32} : {gt16, lt16, eq16};
    wire [2:0] obsSteps = useWide ? steps32 : steps16;

    localparam logic [2:0] EXP_GT = 3'b100;
    localparam logic [2:0] EXP_LT = 3'b010;
    localparam logic [2:0] EXP_EQ = 3'b001;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive request-side inputs of the selected instance.
    task automatic applyStimulus(input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic s);
        if (useWide) begin
            valid32 = valid; a32 = a; b32 = b; sgn32 = s;
        end else begin
            valid16 = valid; a16 = a[15:0]; b16 = b[15:0]; sgn16 = s;
        end
    endtask

    task automatic setConsumer(input logic rdy);
        if (useWide) cons32 = rdy;
        else         cons16 = rdy;
    endtask

    // Offer one request at a negedge; returns at the negedge after the
    // accept edge. Optionally scrubs the operands right after acceptance.
    task automatic startCompare(input string tag, input logic [31:0] a,
                                input logic [31:0] b, input logic s,
                                input bit zeroAfter);
        checkOutput({tag, "/ready_before"}, obsReady, 1);
        applyStimulus(1'b1, a, b, s);
        @(negedge clock);
        if (zeroAfter) applyStimulus(1'b0, 0, 0, s);
        else           applyStimulus(1'b0, a, b, s);
    endtask

    // Waits (bounded) for o_VALID and checks latency, result and steps.
    task automatic waitResult(input string tag, input logic [2:0] expRes,
                              input int expSteps);
        int cycles = 0;
        while (!obsValid && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput({tag, "/latency"}, cycles, expSteps);
        checkOutput({tag, "/result"}, obsRes, expRes);
        checkOutput({tag, "/steps"}, obsSteps, expSteps);
    endtask

    // Consume the result and confirm the block is idle again next cycle.
    task automatic releaseResult(input string tag);
        setConsumer(1'b1);
        @(negedge clock);
        setConsumer(1'b0);
        checkOutput({tag, "/valid_after_consume"}, obsValid, 0);
        checkOutput({tag, "/ready_after_consume"}, obsReady, 1);
        checkOutput({tag, "/flags_after_consume"}, {obsRes, obsSteps}, 0);
    endtask

    // Reference: ordering from plain integer arithmetic, steps from the
    // position of the most significant slice in which the operands differ.
    function automatic void refModel(input int width, input int digit,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic s, output logic [2:0] res,
                                     output int steps);
        longint va, vb;
        longint diff;
        int ndig = width / digit;
        if (s) begin
            va = (width == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
            vb = (width == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
        end else begin
            va = longint'(a) & ((64'sd1 <<< width) - 1);
            vb = longint'(b) & ((64'sd1 <<< width) - 1);
        end
        res  = (va > vb) ? EXP_GT : (va < vb) ? EXP_LT : EXP_EQ;
        diff = (longint'(a) ^ longint'(b)) & ((64'sd1 <<< width) - 1);
        steps = ndig;
        for (int k = 0; k < ndig; k++) begin
            if (((diff >> (k * digit)) & ((64'sd1 <<< digit) - 1)) != 0) steps = ndig - k;
        end
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [2:0]  expRes;
        int          expSteps;

        reset = 1'b1;
        valid16 = 0; a16 = 0; b16 = 0; sgn16 = 0; cons16 = 0;
        valid32 = 0; a32 = 0; b32 = 0; sgn32 = 0; cons32 = 0;

        // Reset state.
        repeat (2) @(negedge clock);
        checkOutput("reset/ready_low", obsReady, 0);
        checkOutput("reset/valid_low", obsValid, 0);
        checkOutput("reset/flags_low", {obsRes, obsSteps}, 0);
        reset = 1'b0;
        #1;
        checkOutput("reset/ready_after_release", obsReady, 1);
        @(negedge clock);

        // Directed cases on the 16-bit, 4-bit-slice instance.
        startCompare("eq_full", 32'h1234, 32'h1234, 1'b0, 1'b0);
        waitResult("eq_full", EXP_EQ, 4);
        releaseResult("eq_full");

        startCompare("gt_unsigned", 32'h9000, 32'h1FFF, 1'b0, 1'b0);
        waitResult("gt_unsigned", EXP_GT, 1);
        releaseResult("gt_unsigned");

        startCompare("lt_signed", 32'h9000, 32'h1FFF, 1'b1, 1'b0);
        waitResult("lt_signed", EXP_LT, 1);
        releaseResult("lt_signed");

        startCompare("gt_signed_neg", 32'hFFFF, 32'hFFFE, 1'b1, 1'b0);
        waitResult("gt_signed_neg", EXP_GT, 4);
        releaseResult("gt_signed_neg");

        startCompare("lt_scrubbed", 32'h12E0, 32'h12F0, 1'b0, 1'b1);
        waitResult("lt_scrubbed", EXP_LT, 3);
        releaseResult("lt_scrubbed");

        // Backpressure: result held while the consumer stalls.
        startCompare("hold", 32'h5678, 32'h5679, 1'b0, 1'b0);
        waitResult("hold", EXP_LT, 4);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i[0], 32'hFFFF, 32'h0000, 1'b0);
            @(negedge clock);
            checkOutput("hold/result_stable", {obsValid, obsRes, obsSteps}, {1'b1, EXP_LT, 3'd4});
            checkOutput("hold/ready_low", obsReady, 0);
        end
        applyStimulus(1'b0, 0, 0, 1'b0);
        releaseResult("hold");
        @(negedge clock);
        checkOutput("hold/no_second_accept_valid", obsValid, 0);
        checkOutput("hold/no_second_accept_ready", obsReady, 1);

        // Reset during the second scan step.
        startCompare("rst_scan", 32'h1234, 32'h1234, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rst_scan/ready", obsReady, 0);
        checkOutput("rst_scan/outputs", {obsValid, obsRes, obsSteps}, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_scan/ready_after_release", obsReady, 1);
        @(negedge clock);
        checkOutput("rst_scan/no_stale_result", obsValid, 0);
        startCompare("after_rst", 32'h0001, 32'h0002, 1'b0, 1'b0);
        waitResult("after_rst", EXP_LT, 4);

        // Reset while a result is held: outputs clear without a clock edge.
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_done/outputs_async", {obsValid, obsRes, obsSteps}, 0);
        checkOutput("rst_done/ready", obsReady, 0);
        @(negedge clock);
        reset = 1'b0;
        cons16 = 1'b0;
        #1;
        checkOutput("rst_done/ready_after_release", obsReady, 1);
        @(negedge clock);

        // Randomised run on the 32-bit, 8-bit-slice instance.
        useWide = 1'b1;
        #1;
        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = ra;
                2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = ra ^ 32'h8000_0000;
            endcase
            rs = 1'($urandom_range(0, 1));
            refModel(32, 8, ra, rb, rs, expRes, expSteps);
            startCompare("rand", ra, rb, rs, 1'b1);
            waitResult("rand", expRes, expSteps);
            releaseResult("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
